// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a valid/ready input and a one-word holding register.
// Optional parity slot is built only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
    parameter int FREQ      = 50_000_000,
    parameter int RATE      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_tx
);

    localparam int P  = FREQ / RATE;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] P_LAST    = CW'(P - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (P < 2 || DATA_BITS < 5 || DATA_BITS > 9 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
            PARITY < 0 || PARITY > 2) begin : g_bad_param
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;
    logic                 tx_q;
    logic                 busy_q;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = (PARITY != 0);
    logic par_bit;
`endif

    logic                 sym_end;
    logic                 frame_end;
    logic                 accept;
    logic                 load_hold;
    logic                 load_in;
    logic                 to_hold;
    logic [DATA_BITS-1:0] next_word;

    assign sym_end   = (baud_cnt == P_LAST);
    assign frame_end = (state == S_STOP) && sym_end && (stop_idx == STOP_LAST);
    assign accept    = i_valid && !hold_full;
    // A word arriving exactly as the last stop bit ends skips the holding register.
    assign load_hold = frame_end && hold_full;
    assign load_in   = accept && ((state == S_IDLE) || frame_end);
    assign to_hold   = accept && !((state == S_IDLE) || frame_end);
    assign next_word = load_hold ? hold_reg : i_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shifter   <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            if (to_hold) begin
                hold_reg  <= i_data;
                hold_full <= 1'b1;
            end
            if (load_hold || load_in) begin
                if (load_hold) hold_full <= 1'b0;
                shifter  <= next_word;
                state    <= S_START;
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_bit  <= (^next_word) ^ (PARITY == 2);
`endif
            end else if (state != S_IDLE) begin
                if (!sym_end) begin
                    baud_cnt <= baud_cnt + 1'b1;
                end else begin
                    baud_cnt <= '0;
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            tx_q    <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                        S_DATA: begin
                            if (bit_idx == BIT_LAST) begin
                                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                                if (HAS_PAR) begin
                                    state <= S_PARITY;
                                    tx_q  <= par_bit;
                                end else
`endif
                                begin
                                    state <= S_STOP;
                                    tx_q  <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                tx_q    <= shifter[0];
                                shifter <= shifter >> 1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        S_PARITY: begin
                            state <= S_STOP;
                            tx_q  <= 1'b1;
                        end
`endif
                        S_STOP: begin
                            if (stop_idx == STOP_LAST) begin
                                state  <= S_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                stop_idx <= stop_idx + 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_ready = !hold_full;
    assign o_busy  = busy_q;
    assign o_tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame tables for 8N1, back-to-back, 5-bit/2-stop, parity and reset abort.
module tb_uart_tx_frame;

    localparam int P      = 8;
    localparam int LOGMAX = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d8 = '0, dpe = '0, dpo = '0;
    logic [4:0] d5 = '0;
    logic v8 = 1'b0, v5 = 1'b0, vpe = 1'b0, vpo = 1'b0;
    logic [3:0] rdy, bsy, txo;

    uart_tx_frame #(.FREQ(8), .RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(d8), .i_valid(v8),
        .o_ready(rdy[0]), .o_busy(bsy[0]), .o_tx(txo[0]));
    uart_tx_frame #(.FREQ(8), .RATE(1), .DATA_BITS(5), .STOP_BITS(2), .PARITY(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .i_data(d5), .i_valid(v5),
        .o_ready(rdy[1]), .o_busy(bsy[1]), .o_tx(txo[1]));
    uart_tx_frame #(.FREQ(8), .RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) dut_pe (
        .clk(clk), .rst_n(rst_n), .i_data(dpe), .i_valid(vpe),
        .o_ready(rdy[2]), .o_busy(bsy[2]), .o_tx(txo[2]));
    uart_tx_frame #(.FREQ(8), .RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut_po (
        .clk(clk), .rst_n(rst_n), .i_data(dpo), .i_valid(vpo),
        .o_ready(rdy[3]), .o_busy(bsy[3]), .o_tx(txo[3]));

    int n_vec = 0;
    int n_err = 0;

    int   sel = 0;
    logic log_en = 1'b0;
    int   log_n = 0;
    logic tx_log [LOGMAX];
    logic bsy_log[LOGMAX];
    logic rdy_log[LOGMAX];

    always @(negedge clk) begin
        if (log_en && log_n < LOGMAX) begin
            tx_log[log_n]  = txo[sel];
            bsy_log[log_n] = bsy[sel];
            rdy_log[log_n] = rdy[sel];
            log_n++;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic [8:0] d, input logic v);
        case (s)
            0: begin d8 = d[7:0]; v8 = v; end
            1: begin d5 = d[4:0]; v5 = v; end
            2: begin dpe = d[7:0]; vpe = v; end
            default: begin dpo = d[7:0]; vpo = v; end
        endcase
    endtask

    // Present a word on an idle DUT; logging starts with the cycle after the accept edge.
    task automatic send(input int s, input logic [8:0] d);
        @(negedge clk);
        sel = s;
        drive(s, d, 1'b1);
        @(posedge clk);
        #1;
        log_n  = 0;
        log_en = 1'b1;
        drive(s, ~d, 1'b0);
    endtask

    task automatic wait_log(input int k);
        int t;
        t = 0;
        while (log_n < k && t < 2000) begin
            @(negedge clk);
            t++;
        end
        #1;
        log_en = 1'b0;
        if (log_n < k) begin
            n_vec++;
            n_err++;
            $display("FAIL log_timeout: got %0d samples required %0d", log_n, k);
        end
    endtask

    task automatic chk_frame(input string name, input int base, input int nsym, input logic [15:0] bits);
        logic [7:0] got;
        for (int s = 0; s < nsym; s++) begin
            for (int c = 0; c < P; c++) got[c] = tx_log[base + s * P + c];
            chk($sformatf("%s sym%0d", name, s), {24'h0, got}, bits[s] ? 32'hFF : 32'h00);
        end
    endtask

    function automatic int count_busy(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (bsy_log[i]) c++;
        return c;
    endfunction

    function automatic int count_low(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (!tx_log[i]) c++;
        return c;
    endfunction

    initial begin
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h3C, 10'h278};
        vecs[2] = '{8'h01, 10'h202};
        vecs[3] = '{8'h80, 10'h300};
        vecs[4] = '{8'hFF, 10'h3FE};

        #12;
        chk("reset tx", {28'h0, txo}, 32'hF);
        chk("reset ready", {28'h0, rdy}, 32'hF);
        chk("reset busy", {28'h0, bsy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8N1 table
        for (int i = 0; i < 5; i++) begin
            send(0, {1'b0, vecs[i].data});
            wait_log(90);
            chk_frame($sformatf("8n1_%02h", vecs[i].data), 0, 10, {6'h0, vecs[i].frame});
            chk($sformatf("8n1_%02h busy_len", vecs[i].data), count_busy(90), 80);
            chk($sformatf("8n1_%02h idle_tx", vecs[i].data), {31'h0, tx_log[80]}, 1);
        end

        // back-to-back: 0x00 then 0xFF with i_valid held
        @(negedge clk);
        sel = 0;
        drive(0, 9'h000, 1'b1);
        @(posedge clk);
        #1;
        log_n  = 0;
        log_en = 1'b1;
        @(negedge clk);
        drive(0, 9'h0FF, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 9'h000, 1'b0);
        wait_log(170);
        chk_frame("b2b_00", 0, 10, 16'h0200);
        chk_frame("b2b_ff", 80, 10, 16'h03FE);
        chk("b2b ready_s0", {31'h0, rdy_log[0]}, 1);
        chk("b2b ready_s1", {31'h0, rdy_log[1]}, 0);
        chk("b2b ready_s79", {31'h0, rdy_log[79]}, 0);
        chk("b2b ready_s80", {31'h0, rdy_log[80]}, 1);
        chk("b2b busy_len", count_busy(170), 160);
        chk("b2b busy_end", {31'h0, bsy_log[160]}, 0);

        // 5 data bits, 2 stop bits, with a queued word
        send(1, 9'h01F);
        @(negedge clk);
        drive(1, 9'h00A, 1'b1);
        @(posedge clk);
        #1;
        drive(1, 9'h000, 1'b0);
        wait_log(140);
        chk_frame("5d2s_1f", 0, 8, 16'h00FE);
        chk_frame("5d2s_0a", 64, 8, 16'h00D4);
        chk("5d2s busy_len", count_busy(140), 128);

        // parity variants on 0x07
        send(2, 9'h007);
        wait_log(100);
`ifdef UART_TX_PARITY_EN
        chk_frame("par_even", 0, 11, 16'h060E);
        chk("par_even len", count_busy(100), 88);
`else
        chk_frame("par_even", 0, 10, 16'h020E);
        chk("par_even len", count_busy(100), 80);
`endif
        send(3, 9'h007);
        wait_log(100);
`ifdef UART_TX_PARITY_EN
        chk_frame("par_odd", 0, 11, 16'h040E);
        chk("par_odd len", count_busy(100), 88);
`else
        chk_frame("par_odd", 0, 10, 16'h020E);
        chk("par_odd len", count_busy(100), 80);
`endif

        // reset during data bit 3 with a held word
        send(0, 9'h000);
        @(negedge clk);
        drive(0, 9'h055, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 9'h000, 1'b0);
        repeat (33) @(negedge clk);
        #2;
        chk("pre_rst tx", {31'h0, txo[0]}, 0);
        chk("pre_rst ready", {31'h0, rdy[0]}, 0);
        rst_n = 1'b0;
        #1;
        chk("rst tx", {31'h0, txo[0]}, 1);
        chk("rst ready", {31'h0, rdy[0]}, 1);
        chk("rst busy", {31'h0, bsy[0]}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        log_n  = 0;
        log_en = 1'b1;
        wait_log(150);
        chk("post_rst low_cnt", count_low(150), 0);
        chk("post_rst busy_cnt", count_busy(150), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
